// File: rtl/dpram_pkg.sv
// dpram_pkg: default geometry and word/address types for the 32x1024 dual-port RAM
package dpram_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 10;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    typedef logic [0:ADDR_WIDTH-1] addr_t;
    typedef logic [0:DATA_WIDTH-1] data_t;
endpackage

// File: rtl/dpram_if.sv
// dpram_if: write/read bus of the dual-port RAM
//   wen/waddr/d_in : write port (master drives)
//   ren/raddr      : read port  (master drives)
//   d_out          : registered read data (slave drives)
interface dpram_if #(
    parameter int DW = dpram_pkg::DATA_WIDTH,
    parameter int AW = dpram_pkg::ADDR_WIDTH
);
    logic          wen;
    logic [0:AW-1] waddr;
    logic [0:DW-1] d_in;
    logic          ren;
    logic [0:AW-1] raddr;
    logic [0:DW-1] d_out;
    modport master (output wen, waddr, d_in, ren, raddr, input d_out);
    modport slave  (input wen, waddr, d_in, ren, raddr, output d_out);
endinterface

// File: rtl/dpram_array.sv
// dpram_array: bare storage with one synchronous write port and a combinational read
//   clk     : clock
//   i_wen   : write enable (already qualified by reset upstream)
//   i_waddr : write address, i_d_in : write data
//   i_raddr : read address,  o_rdata : mem[i_raddr], combinational
module dpram_array #(
    parameter int DATA_WIDTH = dpram_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = dpram_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  i_wen,
    input  logic [0:ADDR_WIDTH-1] i_waddr,
    input  logic [0:DATA_WIDTH-1] i_d_in,
    input  logic [0:ADDR_WIDTH-1] i_raddr,
    output logic [0:DATA_WIDTH-1] o_rdata
);
    logic [0:DATA_WIDTH-1] r_mem [0:2**ADDR_WIDTH-1];
    always_ff @(posedge clk)
        if (i_wen) r_mem[i_waddr] <= i_d_in;
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/dpram_32x1024.sv
// dpram_32x1024: simple dual-port RAM, registered read (latency 1), write-first on collision
//   clk : clock, rst : synchronous active-high reset (clears d_out, blocks writes, keeps array)
//   bus : dpram_if slave -- wen/waddr/d_in write, ren/raddr read, d_out registered data
module dpram_32x1024
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH = dpram_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = dpram_pkg::ADDR_WIDTH
) (
    input logic     clk,
    input logic     rst,
    dpram_if.slave  bus
);
    logic                  w_wen;
    logic [0:DATA_WIDTH-1] w_rdata;
    logic [0:DATA_WIDTH-1] w_next;
    logic [0:DATA_WIDTH-1] r_d_out;

    assign w_wen = bus.wen & ~rst;

    dpram_array #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_array (
        .clk     (clk),
        .i_wen   (w_wen),
        .i_waddr (bus.waddr),
        .i_d_in  (bus.d_in),
        .i_raddr (bus.raddr),
        .o_rdata (w_rdata)
    );

    // Same-address write in the read cycle wins: forward the incoming word.
    assign w_next = (bus.wen && bus.waddr == bus.raddr) ? bus.d_in : w_rdata;

    always_ff @(posedge clk)
        if (rst) r_d_out <= '0;
        else if (bus.ren) r_d_out <= w_next;

    assign bus.d_out = r_d_out;
endmodule

// File: tb/tb_dpram_32x1024.sv
// tb_dpram_32x1024: directed self-checking bench for dpram_32x1024
module tb_dpram_32x1024;
    import dpram_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    data_t sb [0:DEPTH-1];

    dpram_if bus ();

    dpram_32x1024 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input data_t d);
        bus.wen = 1'b1; bus.waddr = addr_t'(a); bus.d_in = d; bus.ren = 1'b0;
        sb[a] = d;
        tick();
        bus.wen = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.ren = 1'b1; bus.raddr = '0; bus.wen = 1'b0;
        tick(); tick();
        total++;
        if (bus.d_out !== 32'h00000000) begin
            bad++; $display("FAIL reset_clear d_out=%h expected=%h", bus.d_out, 32'h0);
        end
        rst = 1'b0; bus.ren = 1'b0;
        tick(); tick();
        total++;
        if (bus.d_out !== 32'h00000000) begin
            bad++; $display("FAIL reset_release_hold d_out=%h expected=%h", bus.d_out, 32'h0);
        end
    endtask

    task automatic test_fill_readback();
        for (int a = 0; a < 1023; a++) wr(a, $urandom);
        for (int a = 0; a < 1023; a++) begin
            bus.ren = 1'b1; bus.raddr = addr_t'(a);
            tick();
            total++;
            if (bus.d_out !== sb[a]) begin
                bad++; $display("FAIL fill_read addr=%0d d_out=%h expected=%h", a, bus.d_out, sb[a]);
            end
        end
        bus.ren = 1'b0;
    endtask

    task automatic test_hold();
        wr(5, 32'hDEADBEEF);
        bus.ren = 1'b1; bus.raddr = 10'd5;
        tick();
        total++;
        if (bus.d_out !== 32'hDEADBEEF) begin
            bad++; $display("FAIL hold_read d_out=%h expected=%h", bus.d_out, 32'hDEADBEEF);
        end
        bus.ren = 1'b0; bus.raddr = 10'd6;
        bus.wen = 1'b1; bus.waddr = 10'd5; bus.d_in = 32'h12345678; sb[5] = 32'h12345678;
        tick();
        bus.wen = 1'b0;
        total++;
        if (bus.d_out !== 32'hDEADBEEF) begin
            bad++; $display("FAIL hold_ren0 d_out=%h expected=%h", bus.d_out, 32'hDEADBEEF);
        end
        tick();
        total++;
        if (bus.d_out !== 32'hDEADBEEF) begin
            bad++; $display("FAIL hold_ren0_2 d_out=%h expected=%h", bus.d_out, 32'hDEADBEEF);
        end
    endtask

    task automatic test_collision();
        wr(10, 32'h11111111);
        bus.wen = 1'b1; bus.waddr = 10'd10; bus.d_in = 32'hCAFEF00D;
        bus.ren = 1'b1; bus.raddr = 10'd10;
        tick();
        bus.wen = 1'b0;
        total++;
        if (bus.d_out !== 32'hCAFEF00D) begin
            bad++; $display("FAIL collision_bypass d_out=%h expected=%h", bus.d_out, 32'hCAFEF00D);
        end
        bus.raddr = 10'd5;
        tick();
        total++;
        if (bus.d_out !== 32'h12345678) begin
            bad++; $display("FAIL collision_other d_out=%h expected=%h", bus.d_out, 32'h12345678);
        end
        bus.raddr = 10'd10;
        tick();
        total++;
        if (bus.d_out !== 32'hCAFEF00D) begin
            bad++; $display("FAIL collision_array d_out=%h expected=%h", bus.d_out, 32'hCAFEF00D);
        end
        bus.ren = 1'b0;
    endtask

    task automatic test_independent();
        wr(0, 32'h0000FFFF);
        bus.wen = 1'b1; bus.waddr = 10'd1023; bus.d_in = 32'hA5A5A5A5;
        bus.ren = 1'b1; bus.raddr = 10'd0;
        tick();
        bus.wen = 1'b0;
        total++;
        if (bus.d_out !== 32'h0000FFFF) begin
            bad++; $display("FAIL indep_old d_out=%h expected=%h", bus.d_out, 32'h0000FFFF);
        end
        bus.raddr = 10'd1023;
        tick();
        total++;
        if (bus.d_out !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL indep_top d_out=%h expected=%h", bus.d_out, 32'hA5A5A5A5);
        end
        bus.ren = 1'b0;
    endtask

    task automatic test_reset_mid();
        wr(3, 32'h0BADF00D);
        rst = 1'b1;
        bus.wen = 1'b1; bus.waddr = 10'd3; bus.d_in = 32'hFFFFFFFF;
        bus.ren = 1'b1; bus.raddr = 10'd3;
        tick();
        total++;
        if (bus.d_out !== 32'h00000000) begin
            bad++; $display("FAIL midreset_clear d_out=%h expected=%h", bus.d_out, 32'h0);
        end
        rst = 1'b0; bus.wen = 1'b0;
        tick();
        total++;
        if (bus.d_out !== 32'h0BADF00D) begin
            bad++; $display("FAIL midreset_nowrite d_out=%h expected=%h", bus.d_out, 32'h0BADF00D);
        end
        bus.raddr = 10'd1023;
        tick();
        total++;
        if (bus.d_out !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL midreset_keep d_out=%h expected=%h", bus.d_out, 32'hA5A5A5A5);
        end
        bus.ren = 1'b0;
    endtask

    initial begin
        bus.wen = 1'b0; bus.waddr = '0; bus.d_in = '0;
        bus.ren = 1'b0; bus.raddr = '0;
        test_reset();
        test_fill_readback();
        test_hold();
        test_collision();
        test_independent();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
